// File: rtl/stack_sequencer_pkg.sv
// Shared encodings for the stack sequencer: ARF control codes, stack bounds,
// FSM state codes and the registered control payloads.
package stack_sequencer_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned EXT_W   = DATA_W + 1;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OSEL_W  = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [DATA_W-1:0] STACK_BASE  = 16'h00FF;
  localparam logic [DATA_W-1:0] STACK_LIMIT = 16'h0080;

  // ARF FunSel encodings
  localparam logic [SEL_W-1:0] FS_DEC  = 3'b000;
  localparam logic [SEL_W-1:0] FS_INC  = 3'b001;
  localparam logic [SEL_W-1:0] FS_LOAD = 3'b010;
  localparam logic [SEL_W-1:0] FS_CLR  = 3'b011;

  // ARF RegSel masks, active-low {PC, AR, SP}
  localparam logic [SEL_W-1:0] RS_NONE = 3'b111;
  localparam logic [SEL_W-1:0] RS_SP   = 3'b110;

  localparam logic [OSEL_W-1:0] OSEL_SP = 2'b11;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_PUSH_HI = 3'd1;
  localparam state_t ST_PUSH_LO = 3'd2;
  localparam state_t ST_POP_INC = 3'd3;
  localparam state_t ST_POP_LO  = 3'd4;
  localparam state_t ST_POP_HI  = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  typedef struct packed {
    logic [SEL_W-1:0] reg_sel;
    logic [SEL_W-1:0] fun_sel;
  } arf_ctrl_t;

  typedef struct packed {
    logic              cs;
    logic              wr;
    logic [BYTE_W-1:0] data;
  } mem_ctrl_t;

  // A push needs two free bytes at or above STACK_LIMIT; widened so nothing wraps.
  function automatic logic push_overflow(input logic [DATA_W-1:0] sp);
    return EXT_W'(sp) < (EXT_W'(STACK_LIMIT) + EXT_W'(1));
  endfunction

  // A pop needs two occupied bytes at or below STACK_BASE.
  function automatic logic pop_underflow(input logic [DATA_W-1:0] sp);
    return EXT_W'(sp) > (EXT_W'(STACK_BASE) - EXT_W'(2));
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// Request, ARF control and memory signals of the stack sequencer, bundled.
interface stack_sequencer_if;

  logic                                      start;
  logic                                      op;
  logic [stack_sequencer_pkg::DATA_W-1:0]    push_data;
  logic [stack_sequencer_pkg::DATA_W-1:0]    arf_out_d;
  logic [stack_sequencer_pkg::BYTE_W-1:0]    mem_data_out;
  logic [stack_sequencer_pkg::SEL_W-1:0]     arf_reg_sel;
  logic [stack_sequencer_pkg::SEL_W-1:0]     arf_fun_sel;
  logic [stack_sequencer_pkg::OSEL_W-1:0]    arf_out_d_sel;
  logic                                      mem_cs;
  logic                                      mem_wr;
  logic [stack_sequencer_pkg::BYTE_W-1:0]    mem_data_in;
  logic [stack_sequencer_pkg::DATA_W-1:0]    pop_data;
  logic                                      busy;
  logic                                      done;
  logic                                      error;

  // Sequencer side
  modport master (
    input  start, op, push_data, arf_out_d, mem_data_out,
    output arf_reg_sel, arf_fun_sel, arf_out_d_sel,
           mem_cs, mem_wr, mem_data_in, pop_data, busy, done, error
  );

  // Control unit / ARF / memory side
  modport slave (
    output start, op, push_data, arf_out_d, mem_data_out,
    input  arf_reg_sel, arf_fun_sel, arf_out_d_sel,
           mem_cs, mem_wr, mem_data_in, pop_data, busy, done, error
  );

endinterface

// File: rtl/stack_sequencer.sv
// Multi-cycle 16-bit PUSH/POP through SP, split into two byte accesses.
// Every output is a register loaded from the decode of the next state.
module stack_sequencer
  import stack_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  stack_sequencer_if.master bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] push_data_q, push_data_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  arf_ctrl_t         arf_q, arf_d;
  mem_ctrl_t         mem_q, mem_d;
  logic              push_err;
  logic              pop_err;

  // Next state, latched operands and next registered outputs.
  always_comb begin
    state_d     = state_q;
    push_data_d = push_data_q;
    pop_data_d  = pop_data_q;
    error_d     = error_q;
    push_err    = push_overflow(bus.arf_out_d);
    pop_err     = pop_underflow(bus.arf_out_d);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          push_data_d = bus.push_data;
          if (bus.op) begin
            error_d = pop_err;
            state_d = pop_err ? ST_DONE : ST_POP_INC;
          end else begin
            error_d = push_err;
            state_d = push_err ? ST_DONE : ST_PUSH_HI;
          end
        end
      end
      ST_PUSH_HI: state_d = ST_PUSH_LO;
      ST_PUSH_LO: state_d = ST_DONE;
      ST_POP_INC: state_d = ST_POP_LO;
      ST_POP_LO: begin
        pop_data_d[BYTE_W-1:0] = bus.mem_data_out;
        state_d                = ST_POP_HI;
      end
      ST_POP_HI: begin
        pop_data_d[DATA_W-1:BYTE_W] = bus.mem_data_out;
        state_d                     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    arf_d  = '{reg_sel: RS_NONE, fun_sel: FS_DEC};
    mem_d  = '{cs: 1'b1, wr: 1'b0, data: '0};
    busy_d = 1'b0;
    done_d = 1'b0;

    // Writes land at the old SP while the ARF decrements on the same edge.
    case (state_d)
      ST_PUSH_HI: begin
        arf_d  = '{reg_sel: RS_SP, fun_sel: FS_DEC};
        mem_d  = '{cs: 1'b0, wr: 1'b1, data: push_data_d[DATA_W-1:BYTE_W]};
        busy_d = 1'b1;
      end
      ST_PUSH_LO: begin
        arf_d  = '{reg_sel: RS_SP, fun_sel: FS_DEC};
        mem_d  = '{cs: 1'b0, wr: 1'b1, data: push_data_d[BYTE_W-1:0]};
        busy_d = 1'b1;
      end
      ST_POP_INC: begin
        arf_d  = '{reg_sel: RS_SP, fun_sel: FS_INC};
        busy_d = 1'b1;
      end
      ST_POP_LO: begin
        arf_d  = '{reg_sel: RS_SP, fun_sel: FS_INC};
        mem_d  = '{cs: 1'b0, wr: 1'b0, data: '0};
        busy_d = 1'b1;
      end
      ST_POP_HI: begin
        mem_d  = '{cs: 1'b0, wr: 1'b0, data: '0};
        busy_d = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset drops any in-flight strobes at once.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      push_data_q <= '0;
      pop_data_q  <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arf_q       <= '{reg_sel: RS_NONE, fun_sel: FS_DEC};
      mem_q       <= '{cs: 1'b1, wr: 1'b0, data: '0};
    end else begin
      state_q     <= state_d;
      push_data_q <= push_data_d;
      pop_data_q  <= pop_data_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      arf_q       <= arf_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.arf_reg_sel   = arf_q.reg_sel;
  assign bus.arf_fun_sel   = arf_q.fun_sel;
  assign bus.arf_out_d_sel = OSEL_SP;
  assign bus.mem_cs        = mem_q.cs;
  assign bus.mem_wr        = mem_q.wr;
  assign bus.mem_data_in   = mem_q.data;
  assign bus.pop_data      = pop_data_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: ARF/memory model plus a Done-driven scoreboard.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  typedef struct {
    logic        err;
    logic [15:0] pop;
    logic [15:0] sp;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sp_ld;
  logic [15:0] sp_ld_val;
  logic        mem_clr;
  logic [15:0] sp;
  logic [7:0]  mem [256];
  int          cyc = 0;
  int          cs_cnt = 0;
  int          total = 0;
  int          bad = 0;
  int          c0;
  exp_t        q[$];

  always #5 clk = ~clk;

  stack_sequencer_if bus();

  stack_sequencer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ARF SP register and byte memory addressed by SP
  always @(posedge clk) begin
    if (sp_ld) sp <= sp_ld_val;
    else if (!bus.arf_reg_sel[0]) begin
      case (bus.arf_fun_sel)
        FS_DEC:  sp <= sp - 16'd1;
        FS_INC:  sp <= sp + 16'd1;
        FS_CLR:  sp <= 16'd0;
        default: ;
      endcase
    end
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (!bus.mem_cs && bus.mem_wr) begin
      mem[sp[7:0]] <= bus.mem_data_in;
    end
  end

  assign bus.arf_out_d    = sp;
  assign bus.mem_data_out = mem[sp[7:0]];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!bus.mem_cs) cs_cnt <= cs_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each Done pops one expected completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk({e.name, "_err"},  32'(bus.error),      32'(e.err));
          chk({e.name, "_pop"},  32'(bus.pop_data),   32'(e.pop));
          chk({e.name, "_sp"},   32'(sp),             32'(e.sp));
          chk({e.name, "_lat"},  32'(cyc - e.acc + 1), 32'(e.lat));
          chk({e.name, "_busy"}, 32'(bus.busy),       32'd0);
        end
      end
    end
  end

  task automatic issue(input logic op, input logic [15:0] d, input logic eerr,
                       input logic [15:0] epop, input logic [15:0] esp,
                       input int lat, input string nm, input bit track);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.push_data = d;
    if (track) begin
      e.err = eerr; e.pop = epop; e.sp = esp; e.lat = lat; e.acc = cyc + 1; e.name = nm;
      q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic set_sp(input logic [15:0] v);
    @(negedge clk);
    sp_ld = 1'b1; sp_ld_val = v;
    @(negedge clk);
    sp_ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1; sp_ld = 1'b0; sp_ld_val = '0;
    bus.start = 1'b0; bus.op = 1'b0; bus.push_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_reg_sel", 32'(bus.arf_reg_sel),   32'h7);
    chk("rst_fun_sel", 32'(bus.arf_fun_sel),   32'h0);
    chk("rst_osel",    32'(bus.arf_out_d_sel), 32'h3);
    chk("rst_cs",      32'(bus.mem_cs),        32'h1);
    chk("rst_wr",      32'(bus.mem_wr),        32'h0);
    chk("rst_din",     32'(bus.mem_data_in),   32'h0);
    chk("rst_pop",     32'(bus.pop_data),      32'h0);
    chk("rst_err",     32'(bus.error),         32'h0);
    chk("rst_busy",    32'(bus.busy),          32'h0);
    chk("rst_done",    32'(bus.done),          32'h0);
    mem_clr = 1'b0; rst_n = 1'b1;

    set_sp(16'h00FF);
    issue(1'b0, 16'hBEEF, 1'b0, 16'h0000, 16'h00FD, 3, "push_beef", 1'b1);
    drain();
    chk("mem_00ff", 32'(mem[8'hFF]), 32'hBE);
    chk("mem_00fe", 32'(mem[8'hFE]), 32'hEF);

    issue(1'b1, 16'h0000, 1'b0, 16'hBEEF, 16'h00FF, 4, "pop_beef", 1'b1);
    drain();

    c0 = cs_cnt;
    issue(1'b1, 16'h0000, 1'b1, 16'hBEEF, 16'h00FF, 1, "pop_empty", 1'b1);
    drain();
    chk("pop_empty_no_cs", 32'(cs_cnt), 32'(c0));

    set_sp(16'h0080);
    c0 = cs_cnt;
    issue(1'b0, 16'h1234, 1'b1, 16'hBEEF, 16'h0080, 1, "push_full", 1'b1);
    drain();
    chk("push_full_no_cs", 32'(cs_cnt), 32'(c0));
    chk("push_full_mem",   32'(mem[8'h80]), 32'h00);

    set_sp(16'h0081);
    issue(1'b0, 16'hA55A, 1'b0, 16'hBEEF, 16'h007F, 3, "push_edge", 1'b1);
    drain();
    chk("mem_0081", 32'(mem[8'h81]), 32'hA5);
    chk("mem_0080", 32'(mem[8'h80]), 32'h5A);

    issue(1'b1, 16'h0000, 1'b0, 16'hA55A, 16'h0081, 4, "pop_edge", 1'b1);
    drain();

    // Start pulsed during PUSH_LO must be dropped
    set_sp(16'h00C0);
    issue(1'b0, 16'h1357, 1'b0, 16'hA55A, 16'h00BE, 3, "push_ignore", 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("ignore_sp",   32'(sp),       32'h00BE);
    chk("ignore_busy", 32'(bus.busy), 32'h0);

    // Reset during POP_LO: both increments already applied
    issue(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 0, "pop_rst", 1'b0);
    @(negedge clk);
    chk("pop_lo_cs", 32'(bus.mem_cs), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_reg_sel", 32'(bus.arf_reg_sel), 32'h7);
    chk("rst_mid_cs",      32'(bus.mem_cs),      32'h1);
    chk("rst_mid_busy",    32'(bus.busy),        32'h0);
    chk("rst_mid_sp",      32'(sp),              32'h00C0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_after_sp",   32'(sp),       32'h00C0);
    chk("rst_after_busy", 32'(bus.busy), 32'h0);
    chk("rst_after_pop",  32'(bus.pop_data), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
